// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// Holds the FSM state encoding, default geometry and READ_LAT legality bounds.
package dmem_pkg;

    localparam int DMEM_DATA_W   = 16;
    localparam int DMEM_ADDR_W   = 8;

    localparam int READ_LAT_MIN  = 1;
    localparam int READ_LAT_MAX  = 15;
    localparam int LAT_CNT_W     = 4;

    localparam int STATS_W       = 16;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        WR_WAIT = 2'd2,
        ACK     = 2'd3
    } dmem_state_t;

    // Out-of-range latencies are pulled back into the legal window so the
    // wait counter can never be loaded with a value it cannot represent.
    function automatic int clamp_read_lat(input int lat);
        if (lat < READ_LAT_MIN) begin
            return READ_LAT_MIN;
        end
        if (lat > READ_LAT_MAX) begin
            return READ_LAT_MAX;
        end
        return lat;
    endfunction

endpackage : dmem_pkg

// File: rtl/dmem_array.sv
// Single-port synchronous word array with write enable and a registered read port.
// The read register resets to zero; the storage itself is never reset.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = DMEM_DATA_W,
    parameter int ADDR_W = DMEM_ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the storage has no reset branch so it maps onto block RAM; a reset
    // loop over every word would force it into flops.
    always_ff @(posedge clk) begin
        if (i_we && !reset) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule : dmem_array

// File: rtl/dmem_responder.sv
// Data-memory responder: serves one read or write at a time with a one-cycle D_ack.
// Optional DMEM_STATS_EN adds saturating rd_count/wr_count completion counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DATA_W   = DMEM_DATA_W,
    parameter int ADDR_W   = DMEM_ADDR_W,
    parameter int READ_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] D_addr,
    input  logic              D_rd,
    input  logic              D_wr,
    input  logic [DATA_W-1:0] W_data,
    output logic [DATA_W-1:0] R_data,
    output logic              D_ack,
    output logic              busy,
`ifdef DMEM_STATS_EN
    output logic [STATS_W-1:0] rd_count,
    output logic [STATS_W-1:0] wr_count,
`endif
    output logic              req_err
);

    localparam int                 LAT_EFF  = clamp_read_lat(READ_LAT);
    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LAT_EFF - 1);

    dmem_state_t          r_state;
    dmem_state_t          w_next_state;
    logic [LAT_CNT_W-1:0] r_cnt;
    logic [LAT_CNT_W-1:0] w_cnt_next;
    logic [ADDR_W-1:0]    r_addr;
    logic [DATA_W-1:0]    r_wdata;
    logic                 r_is_rd;
    logic                 r_req_err;

    logic                 w_accept_rd;
    logic                 w_accept_wr;
    logic                 w_conflict;
    logic                 w_mem_we;
    logic                 w_mem_re;
    logic [DATA_W-1:0]    w_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_req_err <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_cnt   <= w_cnt_next;
            if (w_conflict) begin
                r_req_err <= 1'b1;
            end
        end
    end

    // Request capture is pure datapath: only meaningful after an acceptance,
    // so it needs no reset.
    always_ff @(posedge clk) begin
        if (w_accept_rd || w_accept_wr) begin
            r_addr  <= D_addr;
            r_is_rd <= w_accept_rd;
        end
        if (w_accept_wr) begin
            r_wdata <= W_data;
        end
    end

    // NOTE: every output of this block gets a default before the case, so no
    // path can leave a signal unassigned and infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_cnt_next   = r_cnt;
        w_accept_rd  = 1'b0;
        w_accept_wr  = 1'b0;
        w_conflict   = 1'b0;
        w_mem_we     = 1'b0;
        w_mem_re     = 1'b0;

        case (r_state)
            IDLE: begin
                if (D_rd && D_wr) begin
                    w_conflict = 1'b1;
                end else if (D_rd) begin
                    w_accept_rd  = 1'b1;
                    w_cnt_next   = LAT_LOAD;
                    w_next_state = RD_WAIT;
                end else if (D_wr) begin
                    w_accept_wr  = 1'b1;
                    w_next_state = WR_WAIT;
                end
            end
            RD_WAIT: begin
                if (r_cnt == '0) begin
                    w_mem_re     = 1'b1;
                    w_next_state = ACK;
                end else begin
                    w_cnt_next = r_cnt - 1'b1;
                end
            end
            WR_WAIT: begin
                w_mem_we     = 1'b1;
                w_next_state = ACK;
            end
            ACK: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_array (
        .clk     (clk),
        .reset   (reset),
        .i_we    (w_mem_we),
        .i_re    (w_mem_re),
        .i_addr  (r_addr),
        .i_wdata (r_wdata),
        .o_rdata (w_rdata)
    );

`ifdef DMEM_STATS_EN
    logic [STATS_W-1:0] r_rd_count;
    logic [STATS_W-1:0] r_wr_count;

    // Counters bump on the edge that closes the ACK cycle and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_count <= '0;
            r_wr_count <= '0;
        end else if (r_state == ACK) begin
            if (r_is_rd && (r_rd_count != '1)) begin
                r_rd_count <= r_rd_count + 1'b1;
            end
            if (!r_is_rd && (r_wr_count != '1)) begin
                r_wr_count <= r_wr_count + 1'b1;
            end
        end
    end

    assign rd_count = r_rd_count;
    assign wr_count = r_wr_count;
`endif

    assign R_data  = w_rdata;
    assign D_ack   = (r_state == ACK);
    assign busy    = (r_state != IDLE);
    assign req_err = r_req_err;

endmodule : dmem_responder

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at READ_LAT 2, 1 and 5
// share address/data/reset; each has its own request strobes and outputs.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  D_addr;
    logic [15:0] W_data;
    logic        rd_v   [3];
    logic        wr_v   [3];
    logic [15:0] rdata_v[3];
    logic        ack_v  [3];
    logic        busy_v [3];
    logic        err_v  [3];
`ifdef DMEM_STATS_EN
    logic [15:0] rdc_v  [3];
    logic [15:0] wrc_v  [3];
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .READ_LAT(2)) dut (
        .clk(clk), .reset(reset), .D_addr(D_addr), .D_rd(rd_v[0]), .D_wr(wr_v[0]),
        .W_data(W_data), .R_data(rdata_v[0]), .D_ack(ack_v[0]), .busy(busy_v[0]),
`ifdef DMEM_STATS_EN
        .rd_count(rdc_v[0]), .wr_count(wrc_v[0]),
`endif
        .req_err(err_v[0])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .READ_LAT(1)) dut_lat1 (
        .clk(clk), .reset(reset), .D_addr(D_addr), .D_rd(rd_v[1]), .D_wr(wr_v[1]),
        .W_data(W_data), .R_data(rdata_v[1]), .D_ack(ack_v[1]), .busy(busy_v[1]),
`ifdef DMEM_STATS_EN
        .rd_count(rdc_v[1]), .wr_count(wrc_v[1]),
`endif
        .req_err(err_v[1])
    );

    dmem_responder #(.DATA_W(16), .ADDR_W(8), .READ_LAT(5)) dut_lat5 (
        .clk(clk), .reset(reset), .D_addr(D_addr), .D_rd(rd_v[2]), .D_wr(wr_v[2]),
        .W_data(W_data), .R_data(rdata_v[2]), .D_ack(ack_v[2]), .busy(busy_v[2]),
`ifdef DMEM_STATS_EN
        .rd_count(rdc_v[2]), .wr_count(wrc_v[2]),
`endif
        .req_err(err_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Runs one request on instance k; exp_lat counts cycles from the acceptance
    // cycle to the D_ack cycle. addr_alt replaces D_addr while the request waits.
    task automatic do_req(input int k, input logic is_rd, input logic [7:0] addr,
                          input logic [7:0] addr_alt, input logic [15:0] wdata,
                          input logic [15:0] exp_rdata, input int exp_lat,
                          input string tag);
        int   n;
        logic busy_ok;
        @(negedge clk);
        D_addr = addr;
        W_data = wdata;
        if (is_rd) rd_v[k] = 1'b1;
        else       wr_v[k] = 1'b1;
        n       = 0;
        busy_ok = 1'b1;
        while (n < 40) begin
            @(negedge clk);
            n++;
            D_addr = addr_alt;
            W_data = ~wdata;
            if (busy_v[k] !== 1'b1) busy_ok = 1'b0;
            if (ack_v[k] === 1'b1) break;
        end
        rd_v[k] = 1'b0;
        wr_v[k] = 1'b0;
        check({tag, "_latency"}, n, exp_lat);
        check({tag, "_busy"}, busy_ok, 1'b1);
        if (is_rd) check({tag, "_rdata"}, rdata_v[k], exp_rdata);
        @(negedge clk);
        check({tag, "_ack_width"}, ack_v[k], 1'b0);
        check({tag, "_idle"}, busy_v[k], 1'b0);
    endtask

    task automatic do_write(input int k, input logic [7:0] addr, input logic [15:0] d,
                            input string tag);
        do_req(k, 1'b0, addr, addr, d, 16'h0, 2, tag);
    endtask

    task automatic do_read(input int k, input logic [7:0] addr, input logic [15:0] exp_d,
                           input int exp_lat, input string tag);
        do_req(k, 1'b1, addr, addr, 16'h0, exp_d, exp_lat, tag);
    endtask

    initial begin
        logic ack_seen;
        reset  = 1'b1;
        D_addr = 8'h00;
        W_data = 16'h0000;
        for (int i = 0; i < 3; i++) begin
            rd_v[i] = 1'b0;
            wr_v[i] = 1'b0;
        end
        repeat (2) @(negedge clk);
        check("rst_rdata",   rdata_v[0], 16'h0);
        check("rst_ack",     ack_v[0],   1'b0);
        check("rst_busy",    busy_v[0],  1'b0);
        check("rst_req_err", err_v[0],   1'b0);
        reset = 1'b0;

        // Write then read back at the default latency.
        do_write(0, 8'h10, 16'hBEEF, "wr_10");
        do_read (0, 8'h10, 16'hBEEF, 3, "rd_10");

        // Latency sweep on the top address.
        do_write(1, 8'hFF, 16'h1234, "wr_ff_l1");
        do_read (1, 8'hFF, 16'h1234, 2, "rd_ff_l1");
        do_write(2, 8'hFF, 16'h5A5A, "wr_ff_l5");
        do_read (2, 8'hFF, 16'h5A5A, 6, "rd_ff_l5");

        // R_data holds across a write; conflict sets sticky req_err only.
        do_write(0, 8'h30, 16'hCAFE, "wr_30");
        check("rdata_hold", rdata_v[0], 16'hBEEF);
        @(negedge clk);
        D_addr  = 8'h30;
        W_data  = 16'h0000;
        rd_v[0] = 1'b1;
        wr_v[0] = 1'b1;
        @(negedge clk);
        rd_v[0] = 1'b0;
        wr_v[0] = 1'b0;
        check("conf_req_err", err_v[0], 1'b1);
        check("conf_busy",    busy_v[0], 1'b0);
        ack_seen = ack_v[0];
        repeat (3) begin
            @(negedge clk);
            ack_seen = ack_seen | ack_v[0];
        end
        check("conf_no_ack", ack_seen, 1'b0);
        check("conf_sticky", err_v[0], 1'b1);
        do_read(0, 8'h30, 16'hCAFE, 3, "rd_30_after_conf");

        // Address change during RD_WAIT is ignored.
        do_write(0, 8'h20, 16'h1111, "wr_20");
        do_write(0, 8'h21, 16'h2222, "wr_21");
        do_req(0, 1'b1, 8'h20, 8'h21, 16'h0, 16'h1111, 3, "rd_20_addr_swap");

        // Reset during RD_WAIT aborts the read.
        @(negedge clk);
        D_addr  = 8'h10;
        rd_v[0] = 1'b1;
        @(negedge clk);
        check("mid_busy_pre", busy_v[0], 1'b1);
        reset   = 1'b1;
        rd_v[0] = 1'b0;
        @(negedge clk);
        check("mid_rst_busy",    busy_v[0],  1'b0);
        check("mid_rst_ack",     ack_v[0],   1'b0);
        check("mid_rst_rdata",   rdata_v[0], 16'h0);
        check("mid_rst_req_err", err_v[0],   1'b0);
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_no_ack", ack_v[0], 1'b0);

`ifdef DMEM_STATS_EN
        check("stats_rst_rd", rdc_v[0], 16'd0);
        check("stats_rst_wr", wrc_v[0], 16'd0);
        do_write(0, 8'h40, 16'h0040, "st_wr0");
        do_write(0, 8'h41, 16'h0041, "st_wr1");
        do_write(0, 8'h42, 16'h0042, "st_wr2");
        do_read (0, 8'h40, 16'h0040, 3, "st_rd0");
        do_read (0, 8'h42, 16'h0042, 3, "st_rd1");
        check("stats_wr", wrc_v[0], 16'd3);
        check("stats_rd", rdc_v[0], 16'd2);
`endif

        // Memory survives reset; a fresh read completes normally.
        do_read(0, 8'h10, 16'hBEEF, 3, "rd_10_post_rst");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dmem_responder
